// File: rtl/vga_comp_pkg.sv
// ---------------------------------------------------------------------------
// vga_comp_pkg
// Shared types for the VGA layer compositor:
//   - mode_e      : per-layer colour mode (SOLID, SHAPE, BLINK, CYCLE)
//   - FIELD_*     : cfg_field codes for configuration writes
//   - layer_cfg_t : one layer's configuration {fg, bg, step, en, mode}
// PIX_W is the colour width the configuration struct is built for; the
// compositor's COLOR_W defaults to it.
// ---------------------------------------------------------------------------
package vga_comp_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_SHAPE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CYCLE = 2'd3
  } mode_e;

  localparam logic [1:0] FIELD_FG   = 2'd0;
  localparam logic [1:0] FIELD_BG   = 2'd1;
  localparam logic [1:0] FIELD_CTRL = 2'd2;  // data[2] enable, data[1:0] mode
  localparam logic [1:0] FIELD_STEP = 2'd3;

  typedef struct packed {
    logic [PIX_W-1:0] fg;
    logic [PIX_W-1:0] bg;
    logic [PIX_W-1:0] step;
    logic             en;
    mode_e            mode;
  } layer_cfg_t;

endpackage

// File: rtl/vga_prio_encoder.sv
// ---------------------------------------------------------------------------
// vga_prio_encoder
// Fixed-priority encoder: reports the index of the lowest set request bit.
// Ports:
//   i_req   [NUM_LAYERS] request vector (layer_hit & enable)
//   o_any                at least one request bit set
//   o_index [LW]         index of lowest set bit (0 when o_any is low)
// ---------------------------------------------------------------------------
module vga_prio_encoder
  import vga_comp_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int LW         = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] i_req,
  output logic                  o_any,
  output logic [LW-1:0]         o_index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_any   = 1'b0;
    o_index = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any   = 1'b1;
        o_index = LW'(i);
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
// Two-stage pixel compositor. Resolves NUM_LAYERS prioritised layers (bit 0
// highest) into one registered RGB value per pixel. Layer configuration is
// double-buffered: writes land in a pending bank and are copied to the active
// bank on frame_start or cfg_apply.
// Ports:
//   clk_crystal  pixel clock
//   reset        synchronous, active-high
//   pix_valid    visible-area flag (output forced to 0 when low)
//   frame_start  one-cycle pulse at the first pixel of a frame
//   layer_hit    per-layer region flags
//   layer_shape  per-layer shape-mask flags
//   cfg_we/cfg_layer/cfg_field/cfg_data  pending-bank write port
//   cfg_apply    immediate pending->active commit
//   rgb          registered pixel colour (latency 2)
//   rgb_valid    pix_valid aligned with rgb
//   frame_cnt    frame counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module vga_layer_compositor
  import vga_comp_pkg::*;
#(
  parameter int                 NUM_LAYERS  = 8,
  parameter int                 COLOR_W     = PIX_W,
  parameter logic [COLOR_W-1:0] BACKDROP    = '0,
  parameter int                 BLINK_SHIFT = 4,
  parameter int                 LW          = $clog2(NUM_LAYERS)
) (
  input  logic                  clk_crystal,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  frame_start,
  input  logic [NUM_LAYERS-1:0] layer_hit,
  input  logic [NUM_LAYERS-1:0] layer_shape,
  input  logic                  cfg_we,
  input  logic [LW-1:0]         cfg_layer,
  input  logic [1:0]            cfg_field,
  input  logic [COLOR_W-1:0]    cfg_data,
  input  logic                  cfg_apply,
  output logic [COLOR_W-1:0]    rgb,
  output logic                  rgb_valid,
  output logic [15:0]           frame_cnt
);

  localparam int PROD_W = COLOR_W + 8;

  function automatic logic [COLOR_W-1:0] layer_color(
    input layer_cfg_t c,
    input logic       shape,
    input logic       blink_phase,
    input logic [7:0] cyc
  );
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic [COLOR_W-1:0] inc;
    fg  = COLOR_W'(c.fg);
    bg  = COLOR_W'(c.bg);
    // Only the low COLOR_W bits of STEP * cyc survive; wrap is intended.
    inc = COLOR_W'(PROD_W'(c.step) * PROD_W'(cyc));
    case (c.mode)
      MODE_SOLID: layer_color = fg;
      MODE_SHAPE: layer_color = shape ? fg : bg;
      MODE_BLINK: layer_color = (shape && blink_phase) ? fg : bg;
      default:    layer_color = fg + inc;
    endcase
  endfunction

  layer_cfg_t r_pend [NUM_LAYERS];
  layer_cfg_t r_act  [NUM_LAYERS];
  layer_cfg_t w_pend_nxt [NUM_LAYERS];
  logic       w_wr_ok;
  logic       w_commit;
  logic [15:0] r_frame_cnt;

  assign w_wr_ok  = cfg_we && (int'(cfg_layer) < NUM_LAYERS);
  assign w_commit = frame_start || cfg_apply;

  // Pending bank with this cycle's write folded in, so a commit in the same
  // cycle as a write captures that write.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) begin
      case (cfg_field)
        FIELD_FG:   w_pend_nxt[cfg_layer].fg   = PIX_W'(cfg_data);
        FIELD_BG:   w_pend_nxt[cfg_layer].bg   = PIX_W'(cfg_data);
        FIELD_CTRL: begin
          w_pend_nxt[cfg_layer].en   = cfg_data[2];
          w_pend_nxt[cfg_layer].mode = mode_e'(cfg_data[1:0]);
        end
        default:    w_pend_nxt[cfg_layer].step = PIX_W'(cfg_data);
      endcase
    end
  end

  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
      r_frame_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_commit) r_act <= w_pend_nxt;
      if (frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;

  logic [NUM_LAYERS-1:0] w_en;
  logic                  w_any;
  logic [LW-1:0]         w_idx;

  always_comb begin
    w_en = '0;
    for (int i = 0; i < NUM_LAYERS; i++) w_en[i] = r_act[i].en;
  end

  vga_prio_encoder #(
    .NUM_LAYERS (NUM_LAYERS),
    .LW         (LW)
  ) u_prio (
    .i_req   (layer_hit & w_en),
    .o_any   (w_any),
    .o_index (w_idx)
  );

  // ---- stage 1: winner index, hit-any, winner shape, pixel valid ----
  logic          r_vld_p1;
  logic          r_any_p1;
  logic [LW-1:0] r_idx_p1;
  logic          r_shape_p1;

  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_any_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= pix_valid;
      r_any_p1 <= w_any;
    end
  end

  always_ff @(posedge clk_crystal) begin
    r_idx_p1   <= w_idx;
    r_shape_p1 <= layer_shape[w_idx];
  end

  // ---- stage 2: colour from active config and current frame_cnt ----
  logic [COLOR_W-1:0] w_color_p1;
  logic [COLOR_W-1:0] r_rgb_p2;
  logic               r_vld_p2;

  assign w_color_p1 = layer_color(r_act[r_idx_p1], r_shape_p1,
                                  r_frame_cnt[BLINK_SHIFT], r_frame_cnt[7:0]);

  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      r_rgb_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (!r_vld_p1)     r_rgb_p2 <= '0;
      else if (r_any_p1) r_rgb_p2 <= w_color_p1;
      else               r_rgb_p2 <= BACKDROP;
    end
  end

  assign rgb       = r_rgb_p2;
  assign rgb_valid = r_vld_p2;

endmodule

// File: tb/tb_vga_layer_compositor.sv
module tb_vga_layer_compositor;
  import vga_comp_pkg::*;

  logic        clk_crystal = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        frame_start;
  logic [7:0]  layer_hit;
  logic [7:0]  layer_shape;
  logic        cfg_we;
  logic [2:0]  cfg_layer;
  logic [1:0]  cfg_field;
  logic [11:0] cfg_data;
  logic        cfg_apply;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic [15:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  vga_layer_compositor #(
    .NUM_LAYERS  (8),
    .COLOR_W     (12),
    .BACKDROP    (12'h000),
    .BLINK_SHIFT (4)
  ) dut (
    .clk_crystal (clk_crystal),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .layer_hit   (layer_hit),
    .layer_shape (layer_shape),
    .cfg_we      (cfg_we),
    .cfg_layer   (cfg_layer),
    .cfg_field   (cfg_field),
    .cfg_data    (cfg_data),
    .cfg_apply   (cfg_apply),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_crystal = ~clk_crystal;

  task automatic tick();
    @(posedge clk_crystal);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] lyr, input logic [1:0] fld,
                    input logic [11:0] dat, input logic apply);
    cfg_we = 1'b1; cfg_layer = lyr; cfg_field = fld; cfg_data = dat;
    cfg_apply = apply;
    tick();
    cfg_we = 1'b0; cfg_apply = 1'b0;
  endtask

  task automatic fstart(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
  endtask

  // Present one pixel and check rgb two edges later.
  task automatic pix(input string tag, input logic [7:0] hit, input logic [7:0] shp,
                     input logic vld, input logic [11:0] exp);
    layer_hit = hit; layer_shape = shp; pix_valid = vld;
    tick();
    tick();
    chk(tag, {4'h0, rgb}, {4'h0, exp});
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
    layer_hit = '0; layer_shape = '0;
    cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0; cfg_apply = 1'b0;
    tick(); tick();
    chk("reset_rgb", {4'h0, rgb}, 16'h0000);
    chk("reset_rgb_valid", {15'h0, rgb_valid}, 16'h0000);
    chk("reset_frame_cnt", frame_cnt, 16'h0000);
    reset = 1'b0;

    // All layers disabled after reset -> backdrop
    pix("backdrop_all_hit", 8'hFF, 8'h00, 1'b1, 12'h000);
    chk("rgb_valid_high", {15'h0, rgb_valid}, 16'h0001);
    chk("frame_cnt_idle", frame_cnt, 16'h0000);

    // L0 solid red, pending only
    wr(3'd0, FIELD_FG, 12'hF00, 1'b0);
    wr(3'd0, FIELD_CTRL, 12'h004, 1'b0);
    pix("pending_not_active", 8'h01, 8'h00, 1'b1, 12'h000);
    fstart(1);
    chk("frame_cnt_1", frame_cnt, 16'h0001);
    // Latency: not visible after one edge, visible after two
    layer_hit = 8'h01;
    tick();
    chk("latency_n1", {4'h0, rgb}, 16'h0000);
    tick();
    chk("latency_n2", {4'h0, rgb}, 16'h0F00);

    // L1 SHAPE white/black, L3 SOLID grey
    wr(3'd1, FIELD_FG, 12'hFFF, 1'b0);
    wr(3'd1, FIELD_BG, 12'h000, 1'b0);
    wr(3'd1, FIELD_CTRL, 12'h005, 1'b0);
    wr(3'd3, FIELD_FG, 12'h555, 1'b0);
    wr(3'd3, FIELD_CTRL, 12'h004, 1'b0);
    apply();
    chk("apply_no_frame_inc", frame_cnt, 16'h0001);
    pix("shape_fg", 8'b0000_1010, 8'hFF, 1'b1, 12'hFFF);
    pix("shape_bg", 8'b0000_1010, 8'h00, 1'b1, 12'h000);
    pix("l3_solid", 8'b0000_1000, 8'h00, 1'b1, 12'h555);
    pix("prio_l0_over_l1", 8'b0000_0011, 8'hFF, 1'b1, 12'hF00);

    // Write in the same cycle as the commit is included
    wr(3'd5, FIELD_FG, 12'h0AB, 1'b0);
    wr(3'd5, FIELD_CTRL, 12'h004, 1'b1);
    pix("write_with_apply", 8'h20, 8'h00, 1'b1, 12'h0AB);

    // Last write in a frame wins
    wr(3'd5, FIELD_FG, 12'h111, 1'b0);
    wr(3'd5, FIELD_FG, 12'h222, 1'b0);
    pix("l5_before_commit", 8'h20, 8'h00, 1'b1, 12'h0AB);
    fstart(1);
    chk("frame_cnt_2", frame_cnt, 16'h0002);
    pix("last_write_wins", 8'h20, 8'h00, 1'b1, 12'h222);

    // L2 BLINK: phase is frame_cnt[4]
    wr(3'd2, FIELD_FG, 12'hFF0, 1'b0);
    wr(3'd2, FIELD_BG, 12'h555, 1'b0);
    wr(3'd2, FIELD_CTRL, 12'h006, 1'b1);
    pix("blink_frame2", 8'h04, 8'hFF, 1'b1, 12'h555);
    fstart(14);
    chk("frame_cnt_16", frame_cnt, 16'h0010);
    pix("blink_frame16", 8'h04, 8'hFF, 1'b1, 12'hFF0);
    pix("blink_frame16_noshape", 8'h04, 8'h00, 1'b1, 12'h555);
    fstart(16);
    pix("blink_frame32", 8'h04, 8'hFF, 1'b1, 12'h555);

    // pix_valid low blanks an enabled hit
    pix("blank_rgb", 8'h01, 8'h00, 1'b0, 12'h000);
    chk("blank_rgb_valid", {15'h0, rgb_valid}, 16'h0000);

    // Mid-stream reset, coinciding with frame_start
    pix("pre_reset", 8'h01, 8'h00, 1'b1, 12'hF00);
    reset = 1'b1; frame_start = 1'b1;
    tick();
    reset = 1'b0; frame_start = 1'b0;
    chk("midreset_rgb", {4'h0, rgb}, 16'h0000);
    chk("midreset_valid", {15'h0, rgb_valid}, 16'h0000);
    chk("midreset_frame_cnt", frame_cnt, 16'h0000);
    pix("cfg_cleared", 8'hFF, 8'hFF, 1'b1, 12'h000);
    apply();
    pix("pending_cleared", 8'hFF, 8'hFF, 1'b1, 12'h000);

    // L4 CYCLE: FG + STEP * frame_cnt[7:0]
    wr(3'd4, FIELD_FG, 12'h000, 1'b0);
    wr(3'd4, FIELD_STEP, 12'h004, 1'b0);
    wr(3'd4, FIELD_CTRL, 12'h007, 1'b0);
    fstart(1);
    chk("first_frame_after_reset", frame_cnt, 16'h0001);
    pix("cycle_f1", 8'h10, 8'h00, 1'b1, 12'h004);
    fstart(2);
    pix("cycle_f3", 8'h10, 8'h00, 1'b1, 12'h00C);
    fstart(1021);
    chk("frame_cnt_1024", frame_cnt, 16'h0400);
    pix("cycle_wrap_1024", 8'h10, 8'h00, 1'b1, 12'h000);
    fstart(1);
    pix("cycle_f1025", 8'h10, 8'h00, 1'b1, 12'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
